cv32e40p_perm_fault_detector_ft: RTL and testbench
==================================================

// Module: cv32e40p_perm_fault_detector_ft
// PURPOSE
// - Upstream producer of the per-unit permanent-fault masks consumed by the ALU/MULT dispatcher.
// - Tracks, per replica, voter-reported mismatches (4 ALUs, 3 MULTs) in leaky saturating counters.
// - Sets a sticky permanent-fault flag when a unit's count reaches THRESHOLD.
// - Transient (SEU) errors decay away; recurring errors become permanent flags.
// PARAMETERS
// CNT_W      4   width of each per-unit error counter
// THRESHOLD  8   count at which a unit is declared permanently faulty (1..2**CNT_W-1)
// DECAY_N    16  consecutive clean ops on a unit before its counter decrements by 1
// PORTS
// clk                      in   1  core clock
// rst_n                    in   1  reset, synchronous, active-low
// clear_i                  in   1  SW clear of all counters and flags (e.g. after repair/BIST)
// alu_valid_i              in   1  one voted ALU op retires this cycle
// alu_active_i             in   4  replicas that took part in the op (dispatcher clock-gate vector)
// alu_err_i                in   4  per-ALU mismatch vs voted result; qualified by valid & active
// mult_valid_i             in   1  one voted MULT op retires this cycle
// mult_err_i               in   3  per-MULT mismatch; active set = ~permanent_faulty_mult_o
// permanent_faulty_alu_o   out  4  sticky fault flags, to dispatcher
// permanent_faulty_mult_o  out  3  sticky fault flags, to dispatcher
// new_fault_o              out  1  1-cycle pulse when any flag rises
// ambiguous_o              out  1  1-cycle pulse when an op's error report was discarded
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): all counters, streaks and flags = 0; new_fault_o = 0; ambiguous_o = 0.
// - Priority at each edge: rst_n > clear_i > updates. clear_i zeroes the same state as reset.
//   A clear_i coincident with a threshold-crossing error leaves flags at 0 and suppresses new_fault_o.
// - ALU and MULT paths are independent; both update in the same cycle if both valids are high.
// - Qualification per op (per path):
//   - eff_err = err & active & ~flag.
//   - Accepted only if popcount(active & ~flag) >= 3 and popcount(eff_err) == 1.
//   - popcount(eff_err) >= 2, or an error with <3 healthy active units: op ignored for counting,
//     ambiguous_o = 1 next cycle.
//   - popcount(eff_err) == 0: clean op for every healthy active unit.
// - Per-unit counter (only when valid & unit active & flag=0):
//   - Accepted error on this unit: cnt = sat(cnt+1), streak = 0.
//   - Accepted error on another unit: cnt and streak unchanged.
//   - Clean op: streak += 1; when streak reaches DECAY_N-1 and the op is clean,
//     cnt = max(cnt-1, 0) and streak = 0.
//   - Inactive / no valid: hold.
// - Flag: set at the same edge where next cnt >= THRESHOLD; latency 1 cycle from the offending op.
//   Flag is sticky until reset/clear. Counter and streak freeze once the flag is set.
// - new_fault_o: registered, = OR over units of (flag_next & ~flag); one pulse even if several
//   units rise together.
// - Counter saturates at 2**CNT_W-1; never wraps. Streak width = $clog2(DECAY_N); never wraps.
// - Flags never clear on their own; all-ones vectors are legal outputs (dispatcher handles them).
// STRUCTURE
// - cv32e40p_ft_pkg: N_ALU=4, N_MULT=3 localparams, popcount function.
// - Sub-module cv32e40p_fault_counter_ft (one unit: cnt, streak, flag); generated 4x ALU, 3x MULT.
// - Top level holds only qualification logic and the pulse registers.
// TESTING (THRESHOLD=4, DECAY_N=4, CNT_W=4 unless stated)
// 1. Reset: drive errors during rst_n=0 -> all outputs 0; after release, first clean op leaves flags 0.
// 2. Threshold: active=0111, alu_err=0010 on 4 valid ops -> alu flags=0010 the cycle after the
//    4th op; new_fault_o high exactly 1 cycle.
// 3. Decay: 3 errors on ALU0, then 4 clean ops -> cnt=2; 2 more errors are needed to set 0001.
// 4. Ambiguous: active=0111, alu_err=0011 -> no counter change, ambiguous_o pulse.
//    With flags=0011 (2 healthy), alu_err=0100 -> also ambiguous.
// 5. Clear race: ALU2 cnt=3, clear_i=1 in the cycle of the 4th error -> flags=0000, cnt=0, no new_fault_o.
// 6. MULT path plus simultaneity:
//    - mult_err=001 x4 and, in parallel, alu_err=1000 x4 (active=1110) ->
//      mult flags=001, alu flags=1000 on the same cycle, single new_fault_o pulse.
//    - THRESHOLD=15: 20 errors on one unit -> cnt stays 15 (saturates, no wrap) and the flag rises once.

Source files
------------

// File: rtl/cv32e40p_ft_pkg.sv
// Shared sizing and helpers for the permanent-fault detector slice.
package cv32e40p_ft_pkg;

  localparam int N_ALU  = 4;
  localparam int N_MULT = 3;

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/cv32e40p_fault_counter_ft.sv
// One unit's leaky saturating error counter with a sticky permanent-fault flag.
module cv32e40p_fault_counter_ft #(
  parameter int CNT_W     = 4,
  parameter int THRESHOLD = 8,
  parameter int DECAY_N   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  input  logic clean,
  output logic flag,
  output logic rise
);

  localparam int STR_W = (DECAY_N > 1) ? $clog2(DECAY_N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [STR_W-1:0] streak, streak_nxt;
  logic             flag_nxt;

  // Counter and streak freeze once the unit is declared faulty.
  always_comb begin
    cnt_nxt    = cnt;
    streak_nxt = streak;
    if (!flag) begin
      if (inc) begin
        cnt_nxt    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        streak_nxt = '0;
      end else if (clean) begin
        if (streak == STR_W'(DECAY_N - 1)) begin
          cnt_nxt    = (cnt == '0) ? cnt : cnt - CNT_W'(1);
          streak_nxt = '0;
        end else begin
          streak_nxt = streak + STR_W'(1);
        end
      end
    end
    flag_nxt = flag | (cnt_nxt >= CNT_W'(THRESHOLD));
  end

  assign rise = flag_nxt & ~flag;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt    <= '0;
      streak <= '0;
      flag   <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      streak <= streak_nxt;
      flag   <= flag_nxt;
    end
  end

endmodule

// File: rtl/cv32e40p_perm_fault_detector_ft.sv
// Qualifies voter mismatch reports per op and turns recurring per-unit errors into sticky fault masks.
module cv32e40p_perm_fault_detector_ft
  import cv32e40p_ft_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int THRESHOLD = 8,
  parameter int DECAY_N   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              alu_valid_i,
  input  logic [N_ALU-1:0]  alu_active_i,
  input  logic [N_ALU-1:0]  alu_err_i,
  input  logic              mult_valid_i,
  input  logic [N_MULT-1:0] mult_err_i,
  output logic [N_ALU-1:0]  permanent_faulty_alu_o,
  output logic [N_MULT-1:0] permanent_faulty_mult_o,
  output logic              new_fault_o,
  output logic              ambiguous_o
);

  logic [N_ALU-1:0]  alu_healthy, alu_eff, alu_inc, alu_clean, alu_rise;
  logic [N_MULT-1:0] mult_healthy, mult_eff, mult_inc, mult_clean, mult_rise;
  logic [3:0]        alu_n_err, alu_n_h, mult_n_err, mult_n_h;
  logic              alu_accept, alu_is_clean, alu_amb;
  logic              mult_accept, mult_is_clean, mult_amb;

  // A single error is only attributable when at least three healthy units voted.
  always_comb begin
    alu_healthy   = alu_active_i & ~permanent_faulty_alu_o;
    alu_eff       = alu_err_i & alu_healthy;
    alu_n_err     = popcount({{(8-N_ALU){1'b0}}, alu_eff});
    alu_n_h       = popcount({{(8-N_ALU){1'b0}}, alu_healthy});
    alu_accept    = alu_valid_i && (alu_n_err == 4'd1) && (alu_n_h >= 4'd3);
    alu_is_clean  = alu_valid_i && (alu_n_err == 4'd0);
    alu_amb       = alu_valid_i && ((alu_n_err >= 4'd2) || ((alu_n_err == 4'd1) && (alu_n_h < 4'd3)));
    alu_inc       = alu_eff & {N_ALU{alu_accept}};
    alu_clean     = alu_healthy & {N_ALU{alu_is_clean}};

    mult_healthy  = ~permanent_faulty_mult_o;
    mult_eff      = mult_err_i & mult_healthy;
    mult_n_err    = popcount({{(8-N_MULT){1'b0}}, mult_eff});
    mult_n_h      = popcount({{(8-N_MULT){1'b0}}, mult_healthy});
    mult_accept   = mult_valid_i && (mult_n_err == 4'd1) && (mult_n_h >= 4'd3);
    mult_is_clean = mult_valid_i && (mult_n_err == 4'd0);
    mult_amb      = mult_valid_i && ((mult_n_err >= 4'd2) || ((mult_n_err == 4'd1) && (mult_n_h < 4'd3)));
    mult_inc      = mult_eff & {N_MULT{mult_accept}};
    mult_clean    = mult_healthy & {N_MULT{mult_is_clean}};
  end

  for (genvar i = 0; i < N_ALU; i++) begin : g_alu
    cv32e40p_fault_counter_ft #(
      .CNT_W(CNT_W), .THRESHOLD(THRESHOLD), .DECAY_N(DECAY_N)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear_i),
      .inc   (alu_inc[i]),
      .clean (alu_clean[i]),
      .flag  (permanent_faulty_alu_o[i]),
      .rise  (alu_rise[i])
    );
  end

  for (genvar i = 0; i < N_MULT; i++) begin : g_mult
    cv32e40p_fault_counter_ft #(
      .CNT_W(CNT_W), .THRESHOLD(THRESHOLD), .DECAY_N(DECAY_N)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear_i),
      .inc   (mult_inc[i]),
      .clean (mult_clean[i]),
      .flag  (permanent_faulty_mult_o[i]),
      .rise  (mult_rise[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      new_fault_o <= 1'b0;
      ambiguous_o <= 1'b0;
    end else begin
      new_fault_o <= |{alu_rise, mult_rise};
      ambiguous_o <= alu_amb | mult_amb;
    end
  end

endmodule

// File: tb/tb_cv32e40p_perm_fault_detector_ft.sv
// Directed bench: THRESHOLD=4/DECAY_N=4 instance plus a THRESHOLD=15 instance for saturation.
module tb_cv32e40p_perm_fault_detector_ft;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       alu_valid, alu_valid15;
  logic [3:0] alu_active, alu_err;
  logic       mult_valid, mult_valid15;
  logic [2:0] mult_err;
  logic [3:0] flag_alu, flag_alu15;
  logic [2:0] flag_mult, flag_mult15;
  logic       new_fault, new_fault15, ambiguous, ambiguous15;

  int n_total = 0;
  int n_pass  = 0;
  int pulses15;

  always #5 clk = ~clk;

  cv32e40p_perm_fault_detector_ft #(.CNT_W(4), .THRESHOLD(4), .DECAY_N(4)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .clear_i                 (clear),
    .alu_valid_i             (alu_valid),
    .alu_active_i            (alu_active),
    .alu_err_i               (alu_err),
    .mult_valid_i            (mult_valid),
    .mult_err_i              (mult_err),
    .permanent_faulty_alu_o  (flag_alu),
    .permanent_faulty_mult_o (flag_mult),
    .new_fault_o             (new_fault),
    .ambiguous_o             (ambiguous)
  );

  cv32e40p_perm_fault_detector_ft #(.CNT_W(4), .THRESHOLD(15), .DECAY_N(4)) dut15 (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .clear_i                 (clear),
    .alu_valid_i             (alu_valid15),
    .alu_active_i            (alu_active),
    .alu_err_i               (alu_err),
    .mult_valid_i            (mult_valid15),
    .mult_err_i              (mult_err),
    .permanent_faulty_alu_o  (flag_alu15),
    .permanent_faulty_mult_o (flag_mult15),
    .new_fault_o             (new_fault15),
    .ambiguous_o             (ambiguous15)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One cycle of stimulus; outputs are sampled 1ns after the edge that consumed it.
  task automatic op(input logic av, input logic [3:0] act, input logic [3:0] ae,
                    input logic mv, input logic [2:0] me, input logic clr, input logic v15);
    alu_valid   = av;
    alu_active  = act;
    alu_err     = ae;
    mult_valid  = mv;
    mult_err    = me;
    clear       = clr;
    alu_valid15 = v15;
    @(posedge clk);
    #1;
    alu_valid   = 1'b0;
    mult_valid  = 1'b0;
    clear       = 1'b0;
    alu_valid15 = 1'b0;
  endtask

  task automatic do_clear();
    op(1'b0, 4'h0, 4'h0, 1'b0, 3'b000, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; alu_valid = 1'b0; alu_valid15 = 1'b0;
    alu_active = '0; alu_err = '0; mult_valid = 1'b0; mult_valid15 = 1'b0; mult_err = '0;

    // Reset with errors driven
    op(1'b1, 4'hF, 4'h1, 1'b1, 3'b001, 1'b0, 1'b1);
    op(1'b1, 4'hF, 4'h3, 1'b1, 3'b011, 1'b0, 1'b1);
    chk("rst_alu_flags", {4'h0, flag_alu}, 8'h00);
    chk("rst_mult_flags", {5'h0, flag_mult}, 8'h00);
    chk("rst_new_fault", {7'h0, new_fault}, 8'h00);
    chk("rst_ambiguous", {7'h0, ambiguous}, 8'h00);
    rst_n = 1'b1;
    op(1'b1, 4'hF, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("post_rst_clean_flags", {4'h0, flag_alu}, 8'h00);

    // Threshold on ALU1
    do_clear();
    for (int i = 0; i < 3; i++) op(1'b1, 4'h7, 4'h2, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("thr_3rd_flags", {4'h0, flag_alu}, 8'h00);
    chk("thr_3rd_new_fault", {7'h0, new_fault}, 8'h00);
    op(1'b1, 4'h7, 4'h2, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("thr_4th_flags", {4'h0, flag_alu}, 8'h02);
    chk("thr_4th_new_fault", {7'h0, new_fault}, 8'h01);
    op(1'b0, 4'h0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("thr_pulse_drop", {7'h0, new_fault}, 8'h00);
    chk("thr_sticky", {4'h0, flag_alu}, 8'h02);

    // Decay: 3 errors, 4 clean ops -> cnt 2, two more errors needed
    do_clear();
    for (int i = 0; i < 3; i++) op(1'b1, 4'hF, 4'h1, 1'b0, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) op(1'b1, 4'hF, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0);
    op(1'b1, 4'hF, 4'h1, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("decay_1st_extra", {4'h0, flag_alu}, 8'h00);
    op(1'b1, 4'hF, 4'h1, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("decay_2nd_extra", {4'h0, flag_alu}, 8'h01);
    chk("decay_new_fault", {7'h0, new_fault}, 8'h01);

    // Ambiguous: double error, then an under-voted single error
    do_clear();
    op(1'b1, 4'h7, 4'h3, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("amb_double", {7'h0, ambiguous}, 8'h01);
    op(1'b1, 4'h7, 4'h1, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("amb_pulse_drop", {7'h0, ambiguous}, 8'h00);
    op(1'b1, 4'h7, 4'h1, 1'b0, 3'b000, 1'b0, 1'b0);
    op(1'b1, 4'h7, 4'h1, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("amb_no_count", {4'h0, flag_alu}, 8'h00);
    op(1'b1, 4'h7, 4'h1, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("amb_alu0_flag", {4'h0, flag_alu}, 8'h01);
    for (int i = 0; i < 4; i++) op(1'b1, 4'hF, 4'h2, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("amb_alu1_flag", {4'h0, flag_alu}, 8'h03);
    op(1'b1, 4'hF, 4'h4, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("amb_two_healthy", {7'h0, ambiguous}, 8'h01);
    chk("amb_two_healthy_nf", {7'h0, new_fault}, 8'h00);
    chk("amb_two_healthy_flags", {4'h0, flag_alu}, 8'h03);
    op(1'b1, 4'hF, 4'h1, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("amb_masked_err_clean", {7'h0, ambiguous}, 8'h00);

    // Clear racing the threshold-crossing error
    do_clear();
    chk("clear_flags", {4'h0, flag_alu}, 8'h00);
    for (int i = 0; i < 3; i++) op(1'b1, 4'h7, 4'h4, 1'b0, 3'b000, 1'b0, 1'b0);
    op(1'b1, 4'h7, 4'h4, 1'b0, 3'b000, 1'b1, 1'b0);
    chk("race_flags", {4'h0, flag_alu}, 8'h00);
    chk("race_new_fault", {7'h0, new_fault}, 8'h00);
    for (int i = 0; i < 3; i++) op(1'b1, 4'h7, 4'h4, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("race_cnt_zeroed", {4'h0, flag_alu}, 8'h00);
    op(1'b1, 4'h7, 4'h4, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("race_refault", {4'h0, flag_alu}, 8'h04);

    // MULT and ALU crossing together
    do_clear();
    for (int i = 0; i < 3; i++) op(1'b1, 4'hE, 4'h8, 1'b1, 3'b001, 1'b0, 1'b0);
    chk("sim_3rd_alu", {4'h0, flag_alu}, 8'h00);
    chk("sim_3rd_mult", {5'h0, flag_mult}, 8'h00);
    op(1'b1, 4'hE, 4'h8, 1'b1, 3'b001, 1'b0, 1'b0);
    chk("sim_alu_flags", {4'h0, flag_alu}, 8'h08);
    chk("sim_mult_flags", {5'h0, flag_mult}, 8'h01);
    chk("sim_new_fault", {7'h0, new_fault}, 8'h01);
    op(1'b0, 4'h0, 4'h0, 1'b1, 3'b010, 1'b0, 1'b0);
    chk("sim_single_pulse", {7'h0, new_fault}, 8'h00);
    chk("mult_two_healthy_amb", {7'h0, ambiguous}, 8'h01);
    chk("mult_two_healthy_flags", {5'h0, flag_mult}, 8'h01);

    // Saturation instance: 20 errors on ALU0, flag must rise exactly once at the 15th
    do_clear();
    pulses15 = 0;
    for (int i = 0; i < 14; i++) begin
      op(1'b0, 4'hF, 4'h1, 1'b0, 3'b000, 1'b0, 1'b1);
      pulses15 += int'(new_fault15);
    end
    chk("sat_14_flags", {4'h0, flag_alu15}, 8'h00);
    op(1'b0, 4'hF, 4'h1, 1'b0, 3'b000, 1'b0, 1'b1);
    pulses15 += int'(new_fault15);
    chk("sat_15_flags", {4'h0, flag_alu15}, 8'h01);
    for (int i = 0; i < 5; i++) begin
      op(1'b0, 4'hF, 4'h1, 1'b0, 3'b000, 1'b0, 1'b1);
      pulses15 += int'(new_fault15);
    end
    chk("sat_20_flags", {4'h0, flag_alu15}, 8'h01);
    chk("sat_pulse_count", 8'(pulses15), 8'h01);
    chk("sat_main_untouched", {4'h0, flag_alu}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
